// File: rtl/pwm_capture.sv
// Servo PWM receiver: measures high time (reported as ticks-1, servo in_pwm encoding) and
// rising-to-rising period, flagging out-of-window pulses and loss of signal.
module pwm_capture #(
  parameter int CNT_W         = 20,
  parameter int PULSE_MIN     = 300_000 / 37,
  parameter int PULSE_MAX     = 2_500_000 / 37,
  parameter int PERIOD_MIN    = 18_000_000 / 37,
  parameter int PERIOD_MAX    = 22_000_000 / 37,
  parameter int TIMEOUT_TICKS = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pin_pwm,
  output logic [CNT_W-1:0] width_out,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             range_err,
  output logic             timeout,
  output logic             sig_lost
);

  localparam logic [CNT_W-1:0] W_MIN   = CNT_W'(PULSE_MIN);
  localparam logic [CNT_W-1:0] W_MAX   = CNT_W'(PULSE_MAX);
  localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  function automatic logic out_of_range(input logic [CNT_W-1:0] w,
                                        input logic [CNT_W-1:0] p);
    return (w < W_MIN) || (w > W_MAX) || (p < P_MIN) || (p > P_MAX);
  endfunction

  logic       sync1_q, sync2_q, sync3_q;
  logic [1:0] warm_q;
  logic       rise, fall;

  // Edges are only trusted once sync3 holds a real sample, so a pin already high
  // at reset release does not look like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      warm_q  <= 2'd0;
    end else begin
      sync1_q <= pin_pwm;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  assign rise = (warm_q == 2'd3) &&  sync2_q && !sync3_q;
  assign fall = (warm_q == 2'd3) && !sync2_q &&  sync3_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d, per_q, per_d;
  logic [CNT_W-1:0] width_q, width_d, period_q, period_d;
  logic             valid_q, valid_d, err_q, err_d, to_q, to_d, lost_q, lost_d;
  logic             to_hit;

  assign to_hit = (per_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    per_d    = per_q;
    width_d  = width_q;
    period_d = period_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    to_d     = 1'b0;
    lost_d   = lost_q;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_HIGH;
          hi_d    = ONE;
          per_d   = ONE;
        end
      end
      S_HIGH: begin
        if (to_hit) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
          lost_d  = 1'b1;
        end else if (fall) begin
          state_d = S_LOW;
          per_d   = per_q + ONE;
        end else begin
          hi_d    = hi_q + ONE;
          per_d   = per_q + ONE;
        end
      end
      S_LOW: begin
        // A rise on the timeout cycle still publishes; the counters never wrap.
        if (rise) begin
          width_d  = hi_q - ONE;
          period_d = per_q;
          valid_d  = 1'b1;
          lost_d   = 1'b0;
          err_d    = out_of_range(hi_q - ONE, per_q);
          state_d  = S_HIGH;
          hi_d     = ONE;
          per_d    = ONE;
        end else if (to_hit) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
          lost_d  = 1'b1;
        end else begin
          per_d   = per_q + ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      per_q    <= '0;
      width_q  <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      per_q    <= per_d;
      width_q  <= width_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      to_q     <= to_d;
      lost_q   <= lost_d;
    end
  end

  assign width_out  = width_q;
  assign period_out = period_q;
  assign valid      = valid_q;
  assign range_err  = err_q;
  assign timeout    = to_q;
  assign sig_lost   = lost_q;

endmodule
